// File: rtl/debug_slave_pkg.sv
// Shared types and constants for the debug slave command engine.
package debug_slave_pkg;

   // Command engine sequencing states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_ISSUE   = 2'd2
   } state_t;

   // Default configuration
   localparam int DEF_DATA_W      = 38;
   localparam int DEF_IR_W        = 2;
   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_TIMEOUT_CYC = 1024;

   // The take_action flag rides in the MSB of the shifted data word
   localparam int DEF_ACT_BIT = DEF_DATA_W - 1;

   function automatic int act_bit(input int data_w);
      return data_w - 1;
   endfunction

endpackage

// File: rtl/debug_slave_sync_edge.sv
// One TCK-domain level synchroniser followed by a rising-edge detector.
// After reset the detector stays blind until the chain has refilled, so a
// level that was already high when reset released never looks like an edge.
module debug_slave_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;
   logic [STAGES:0]   fill_q;

   // Synchroniser chain, edge history and post-reset refill tracker
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         fill_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
         hist_q <= sync_q[STAGES-1];
         fill_q <= {fill_q[STAGES-1:0], 1'b1};
      end
   end

   // History only reflects the real synchronised level once fill_q is full
   assign rise = sync_q[STAGES-1] & ~hist_q & fill_q[STAGES];

endmodule

// File: rtl/debug_slave_cmd_engine.sv
// Debug slave command engine: turns virtual-JTAG update-DR events into a
// valid/ready command with a one-hot channel select.
// Optional: define DEBUG_SLAVE_CMD_TIMEOUT_EN to abandon commands that are
// not accepted within TIMEOUT_CYC cycles (adds the err_timeout port).
module debug_slave_cmd_engine
   import debug_slave_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int IR_W        = DEF_IR_W,
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vs_udr,
   input  logic              vs_uir,
   input  logic [IR_W-1:0]   ir_in,
   input  logic [DATA_W-1:0] sr,
   output logic [DATA_W-1:0] jdo,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [NUM_CH-1:0] cmd_onehot,
   output logic              cmd_action,
   output logic              uir_pulse,
   output logic              err_overrun,
   output logic              err_illegal,
`ifdef DEBUG_SLAVE_CMD_TIMEOUT_EN
   output logic              err_timeout,
`endif
   input  logic              err_clr
);

   localparam int ACT_BIT = act_bit(DATA_W);

   state_t          state_q, state_d;
   logic            udr_edge, uir_edge;
   logic            legal;
   logic            ovr_set, ill_set;
   logic [IR_W-1:0] ch_q;

   debug_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_udr (
      .clk      (clk),
      .reset    (reset),
      .async_in (vs_udr),
      .rise     (udr_edge)
   );

   debug_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_uir (
      .clk      (clk),
      .reset    (reset),
      .async_in (vs_uir),
      .rise     (uir_edge)
   );

   assign legal   = (int'(ir_in) < NUM_CH);
   // A new update-DR while busy is dropped and flagged
   assign ovr_set = udr_edge && (state_q != ST_IDLE);
   assign ill_set = (state_q == ST_CAPTURE) && !legal;

`ifdef DEBUG_SLAVE_CMD_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   logic [CNT_W-1:0] cnt_q;
   logic             to_hit;

   assign to_hit = (state_q == ST_ISSUE) && !cmd_ready &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // Cycles spent in ISSUE; restarts on every new command
   always_ff @(posedge clk) begin
      if (reset || state_q != ST_ISSUE) cnt_q <= '0;
      else                              cnt_q <= cnt_q + CNT_W'(1);
   end

   // Sticky timeout flag, a new event beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset) err_timeout <= 1'b0;
      else       err_timeout <= to_hit | (err_timeout & ~err_clr);
   end
`else
   logic to_hit;
   assign to_hit = 1'b0;
   wire unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: capture once, then hold the command until accepted
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (udr_edge) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = legal ? ST_ISSUE : ST_IDLE;
         ST_ISSUE:   if (cmd_ready || to_hit) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Capture data and channel from the settled shift register
   always_ff @(posedge clk) begin
      if (reset) begin
         jdo  <= '0;
         ch_q <= '0;
      end else if (state_q == ST_CAPTURE) begin
         jdo  <= sr;
         ch_q <= ir_in;
      end
   end

   // Sticky error flags and the instruction-update pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         err_overrun <= 1'b0;
         err_illegal <= 1'b0;
         uir_pulse   <= 1'b0;
      end else begin
         err_overrun <= ovr_set | (err_overrun & ~err_clr);
         err_illegal <= ill_set | (err_illegal & ~err_clr);
         uir_pulse   <= uir_edge;
      end
   end

   assign cmd_valid  = (state_q == ST_ISSUE);
   assign cmd_action = cmd_valid & jdo[ACT_BIT];

   // Channel decode, forced to zero whenever no command is pending
   always_comb begin
      cmd_onehot = '0;
      for (int i = 0; i < NUM_CH; i++)
         cmd_onehot[i] = cmd_valid && (int'(ch_q) == i);
   end

endmodule
